neuron_bp: RTL and testbench
============================

NEURON_BP -- requirements
Module: neuron_bp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter FBITS, default 24, meaning fractional bits of the signed Q format.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 The ports SHALL be, in order:
- clk  in  1  clock, rising edge.
- rst  in  1  async active-low reset.
- en  in  1  clock enable.
- start  in  1  request one backward pass.
- a_1, a_2, a_3  in  WIDTH each  forward-pass inputs, signed.
- w_1, w_2, w_3  in  WIDTH each  current weights, signed.
- b  in  WIDTH  current bias, signed.
- y  in  WIDTH  forward sigmoid output, signed.
- err  in  WIDTH  upstream error dL/dy, signed.
- lr  in  WIDTH  learning rate, signed.
- delta  out  WIDTH  local gradient, signed.
- e_prev_1, e_prev_2, e_prev_3  out  WIDTH each  error propagated to the previous layer, signed.
- w_1_new, w_2_new, w_3_new  out  WIDTH each  updated weights, signed.
- b_new  out  WIDTH  updated bias, signed.
- busy  out  1  pass in progress.
- done  out  1  one-cycle result-valid strobe.

Function
REQ-005 Multiply SHALL use one shared Q multiplier: full 2*WIDTH signed product, arithmetic shift right by FBITS, low WIDTH bits kept (truncation, no rounding).
REQ-006 FSM states SHALL be IDLE, DERIV, DELTA, SCALE, PROP, UPD, DONE.
REQ-007 In IDLE with en=1 and start=1, the block SHALL capture all data inputs into internal registers and go to DERIV. Inputs are not sampled again until the next capture.
REQ-008 DERIV SHALL compute s = y*(ONE - y), where ONE = 1<<FBITS. It then goes to DELTA.
REQ-009 DELTA SHALL compute delta = err*s and register it onto the delta output. It then goes to SCALE.
REQ-010 SCALE SHALL compute g = lr*delta. It then goes to PROP with the index counter at 1.
REQ-011 PROP SHALL take 3 cycles, index i = 1..3, and compute e_prev_i = delta*w_i using the captured old weights.
REQ-012 In the first PROP cycle, the block SHALL also compute b_new = b - g.
REQ-013 UPD SHALL take 3 cycles, index i = 1..3, and compute w_i_new = w_i - g*a_i. It then goes to DONE.
REQ-014 In DONE, done SHALL be 1 for exactly one enabled cycle. The FSM then returns unconditionally to IDLE.
REQ-015 Latency: done SHALL be observed high after the 9th rising edge that follows the edge which sampled start.
REQ-016 busy SHALL be 1 in every state except IDLE. start SHALL be ignored while busy=1, including the DONE cycle.
REQ-017 With en=0, state, counter, all registers and all outputs SHALL hold. This includes done held high if frozen in DONE.
REQ-018 All outputs SHALL be registered and SHALL hold their values from the last pass until they are overwritten by the next pass.
REQ-019 Add/subtract SHALL wrap modulo 2^WIDTH unless NEURON_BP_SAT_EN is defined.

Reset
REQ-020 When rst=0, the FSM SHALL go to IDLE, the counter to 0, and every output (delta, e_prev_*, w_*_new, b_new, busy, done) to 0, immediately and independent of clk.
REQ-021 A reset asserted mid-pass SHALL abort the pass. No done SHALL follow after release.

Configuration
REQ-022 With NEURON_BP_SAT_EN defined, the subtractions in REQ-012 and REQ-013 SHALL saturate: 0x7FFFFFFF on positive overflow and 0x80000000 on negative overflow (for WIDTH=32).
REQ-023 Without NEURON_BP_SAT_EN, those subtractions SHALL wrap.
REQ-024 The multiply truncation of REQ-005 SHALL be unaffected by NEURON_BP_SAT_EN.

Verification
REQ-025 Nominal pass. Stimulus: y=0x00800000, err=0x01000000, lr=0x00800000, a=(0x01000000, 0x02000000, 0xFF000000), w=(0x00800000, 0x00400000, 0x01000000), b=0.
Required response after 9 edges:
- delta=0x00400000
- e_prev=(0x00200000, 0x00100000, 0x00400000)
- w_new=(0x00600000, 0x00000000, 0x01200000)
- b_new=0xFFE00000
- done high for 1 cycle.
REQ-026 Overflow: same as REQ-025 but lr=0x01000000, w_1=0x7FF00000, a_1=0xFF000000. Required: w_1_new=0x7FFFFFFF with NEURON_BP_SAT_EN, 0x80300000 without.
REQ-027 Busy: start pulsed again in the 3rd busy cycle with different inputs. Required: ignored, results still as REQ-025, exactly one done.
REQ-028 Enable: en=0 held for 5 cycles in the middle of PROP. Required: done delayed by exactly 5 cycles, results as REQ-025.
REQ-029 Reset: rst=0 asserted in UPD. Required: all outputs 0 and busy=0 immediately, no done after release, next start completes normally.
REQ-030 y=0x01000000 (derivative 0). Required: delta=0, e_prev all 0, w_i_new=w_i, b_new=b.

Source files
------------

// File: rtl/neuron_bp.sv
// neuron_bp: backward pass for a single 3-input sigmoid neuron in signed Q format.
//
// A pass is requested with start (while idle and enabled). All data inputs are captured,
// then one shared Q multiplier is time-multiplexed over the sequence
//   s = y*(1-y), delta = err*s, g = lr*delta,
//   e_prev_i = delta*w_i (i = 1..3, b_new = b - g on the first of these),
//   w_i_new = w_i - g*a_i (i = 1..3),
// after which done strobes for one enabled cycle. busy covers every non-idle cycle.
//
// Parameters:
//   WIDTH  data word width in bits
//   FBITS  fractional bits of the Q format
//
// Ports:
//   clk, rst (async, active-low), en (clock enable), start (request a pass)
//   a_1..a_3, w_1..w_3, b, y, err, lr   signed data inputs
//   delta, e_prev_1..3, w_1..3_new, b_new  registered signed results
//   busy, done                          status
//
// Build option:
//   NEURON_BP_SAT_EN  when defined, the bias/weight update subtractions saturate to the
//                     signed range instead of wrapping. Multiplies always truncate.

module neuron_bp #(
    parameter int WIDTH = 32,
    parameter int FBITS = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] a_2,
    input  logic [WIDTH-1:0] a_3,
    input  logic [WIDTH-1:0] w_1,
    input  logic [WIDTH-1:0] w_2,
    input  logic [WIDTH-1:0] w_3,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] err,
    input  logic [WIDTH-1:0] lr,
    output logic [WIDTH-1:0] delta,
    output logic [WIDTH-1:0] e_prev_1,
    output logic [WIDTH-1:0] e_prev_2,
    output logic [WIDTH-1:0] e_prev_3,
    output logic [WIDTH-1:0] w_1_new,
    output logic [WIDTH-1:0] w_2_new,
    output logic [WIDTH-1:0] w_3_new,
    output logic [WIDTH-1:0] b_new,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FBITS;

    typedef enum logic [2:0] {
        StIdle, StDeriv, StDelta, StScale, StProp, StUpd, StDone
    } state_e;

    state_e           state_q;
    logic [1:0]       idx_q;
    logic [WIDTH-1:0] a1_q, a2_q, a3_q, w1_q, w2_q, w3_q, b_q, y_q, err_q, lr_q;
    logic [WIDTH-1:0] s_q, g_q;

    // Subtraction used for the bias and weight updates.
    function automatic logic [WIDTH-1:0] sub_q(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z);
`ifdef NEURON_BP_SAT_EN
        logic [WIDTH:0] diff;
        diff = {x[WIDTH-1], x} - {z[WIDTH-1], z};
        // Sign bit and guard bit disagree only on overflow; guard bit gives the true sign.
        if (diff[WIDTH] != diff[WIDTH-1]) begin
            sub_q = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sub_q = diff[WIDTH-1:0];
        end
`else
        sub_q = x - z;
`endif
    endfunction

    // Operand selection for the shared multiplier.
    logic [WIDTH-1:0] op_a, op_b, a_sel, w_sel;

    always_comb begin
        a_sel = a1_q;
        w_sel = w1_q;
        case (idx_q)
            2'd2:    begin a_sel = a2_q; w_sel = w2_q; end
            2'd3:    begin a_sel = a3_q; w_sel = w3_q; end
            default: begin a_sel = a1_q; w_sel = w1_q; end
        endcase
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_q)
            StDeriv: begin op_a = y_q;   op_b = ONE - y_q; end
            StDelta: begin op_a = err_q; op_b = s_q;       end
            StScale: begin op_a = lr_q;  op_b = delta;     end
            StProp:  begin op_a = delta; op_b = w_sel;     end
            StUpd:   begin op_a = g_q;   op_b = a_sel;     end
            default: ;
        endcase
    end

    // Sign-extend to 2*WIDTH so the unsigned product equals the signed product.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mul_res;
    logic               unused_prod;

    assign prod        = {{WIDTH{op_a[WIDTH-1]}}, op_a} * {{WIDTH{op_b[WIDTH-1]}}, op_b};
    // Arithmetic shift by FBITS then keep the low WIDTH bits == this slice.
    assign mul_res     = prod[FBITS +: WIDTH];
    assign unused_prod = ^prod;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            idx_q    <= 2'd0;
            a1_q     <= '0;
            a2_q     <= '0;
            a3_q     <= '0;
            w1_q     <= '0;
            w2_q     <= '0;
            w3_q     <= '0;
            b_q      <= '0;
            y_q      <= '0;
            err_q    <= '0;
            lr_q     <= '0;
            s_q      <= '0;
            g_q      <= '0;
            delta    <= '0;
            e_prev_1 <= '0;
            e_prev_2 <= '0;
            e_prev_3 <= '0;
            w_1_new  <= '0;
            w_2_new  <= '0;
            w_3_new  <= '0;
            b_new    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (en) begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a1_q    <= a_1;
                        a2_q    <= a_2;
                        a3_q    <= a_3;
                        w1_q    <= w_1;
                        w2_q    <= w_2;
                        w3_q    <= w_3;
                        b_q     <= b;
                        y_q     <= y;
                        err_q   <= err;
                        lr_q    <= lr;
                        busy    <= 1'b1;
                        state_q <= StDeriv;
                    end
                end
                StDeriv: begin
                    s_q     <= mul_res;
                    state_q <= StDelta;
                end
                StDelta: begin
                    delta   <= mul_res;
                    state_q <= StScale;
                end
                StScale: begin
                    g_q     <= mul_res;
                    idx_q   <= 2'd1;
                    state_q <= StProp;
                end
                StProp: begin
                    case (idx_q)
                        2'd1:    e_prev_1 <= mul_res;
                        2'd2:    e_prev_2 <= mul_res;
                        default: e_prev_3 <= mul_res;
                    endcase
                    if (idx_q == 2'd1) begin
                        b_new <= sub_q(b_q, g_q);
                    end
                    if (idx_q == 2'd3) begin
                        idx_q   <= 2'd1;
                        state_q <= StUpd;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                StUpd: begin
                    case (idx_q)
                        2'd1:    w_1_new <= sub_q(w_sel, mul_res);
                        2'd2:    w_2_new <= sub_q(w_sel, mul_res);
                        default: w_3_new <= sub_q(w_sel, mul_res);
                    endcase
                    if (idx_q == 2'd3) begin
                        idx_q   <= 2'd0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_bp.sv
// Directed bench for neuron_bp with hand-computed Q8.24 expectations.

module tb_neuron_bp;

    logic        clk = 1'b0;
    logic        rst, en, start;
    logic [31:0] a_1, a_2, a_3, w_1, w_2, w_3, b, y, err, lr;
    logic [31:0] delta, e_prev_1, e_prev_2, e_prev_3, w_1_new, w_2_new, w_3_new, b_new;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    neuron_bp #(.WIDTH(32), .FBITS(24)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .start    (start),
        .a_1      (a_1),
        .a_2      (a_2),
        .a_3      (a_3),
        .w_1      (w_1),
        .w_2      (w_2),
        .w_3      (w_3),
        .b        (b),
        .y        (y),
        .err      (err),
        .lr       (lr),
        .delta    (delta),
        .e_prev_1 (e_prev_1),
        .e_prev_2 (e_prev_2),
        .e_prev_3 (e_prev_3),
        .w_1_new  (w_1_new),
        .w_2_new  (w_2_new),
        .w_3_new  (w_3_new),
        .b_new    (b_new),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [31:0] yv, errv, lrv, a1v, a2v, a3v, w1v, w2v, w3v, bv);
        y = yv; err = errv; lr = lrv;
        a_1 = a1v; a_2 = a2v; a_3 = a3v;
        w_1 = w1v; w_2 = w2v; w_3 = w3v;
        b = bv;
    endtask

    task automatic apply_nominal();
        apply(32'h0080_0000, 32'h0100_0000, 32'h0080_0000,
              32'h0100_0000, 32'h0200_0000, 32'hFF00_0000,
              32'h0080_0000, 32'h0040_0000, 32'h0100_0000, 32'h0000_0000);
    endtask

    // Pulse start at a negedge, then count negedges until done. Optionally re-pulse start
    // with other inputs at busy cycle restart_at, and drop en for 5 cycles from freeze_at.
    task automatic run_pass(input string tag, input int restart_at, input int freeze_at,
                            input int exp_lat);
        int cyc;
        start = 1'b1;
        @(negedge clk);
        cyc = 0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        while (cyc < 40 && !done) begin
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                apply(32'h0040_0000, 32'h0020_0000, 32'h0010_0000, 32'h0030_0000, 32'h0,
                      32'h0, 32'h0, 32'h0, 32'h0, 32'h0100_0000);
            end
            if (cyc == freeze_at) en = 1'b0;
            if (cyc == freeze_at + 5) en = 1'b1;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        en    = 1'b1;
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " busy in done"}, 32'(busy), 32'd1);
    endtask

    // Hold start through the done cycle; it must be ignored and no further done may follow.
    task automatic finish_pass(input string tag);
        int ndone;
        start = 1'b1;
        apply_nominal();
        @(negedge clk);
        start = 1'b0;
        check({tag, " done one cycle"}, 32'(done), 32'd0);
        check({tag, " idle after done"}, 32'(busy), 32'd0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check({tag, " extra done"}, 32'(ndone), 32'd0);
    endtask

    task automatic check_nominal(input string tag);
        check({tag, " delta"},    delta,    32'h0040_0000);
        check({tag, " e_prev_1"}, e_prev_1, 32'h0020_0000);
        check({tag, " e_prev_2"}, e_prev_2, 32'h0010_0000);
        check({tag, " e_prev_3"}, e_prev_3, 32'h0040_0000);
        check({tag, " w_1_new"},  w_1_new,  32'h0060_0000);
        check({tag, " w_2_new"},  w_2_new,  32'h0000_0000);
        check({tag, " w_3_new"},  w_3_new,  32'h0120_0000);
        check({tag, " b_new"},    b_new,    32'hFFE0_0000);
    endtask

    logic [31:0] exp_w1_ovf;
    int          ndone_rst;

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        start = 1'b0;
        apply_nominal();
        #2 rst = 1'b0;
        #1;
        check("reset delta", delta, 32'h0);
        check("reset w_1_new", w_1_new, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Nominal pass.
        apply_nominal();
        run_pass("nom", -1, -10, 9);
        check_nominal("nom");
        finish_pass("nom");

        // Second start during busy with different inputs must be ignored.
        apply_nominal();
        run_pass("busy", 2, -10, 9);
        check_nominal("busy");
        finish_pass("busy");

        // en low for 5 cycles in the middle of PROP delays done by exactly 5.
        apply_nominal();
        run_pass("en", -1, 4, 14);
        check_nominal("en");
        finish_pass("en");

        // Weight update overflow.
`ifdef NEURON_BP_SAT_EN
        exp_w1_ovf = 32'h7FFF_FFFF;
`else
        exp_w1_ovf = 32'h8030_0000;
`endif
        apply(32'h0080_0000, 32'h0100_0000, 32'h0100_0000,
              32'hFF00_0000, 32'h0200_0000, 32'hFF00_0000,
              32'h7FF0_0000, 32'h0040_0000, 32'h0100_0000, 32'h0000_0000);
        run_pass("ovf", -1, -10, 9);
        check("ovf delta",    delta,    32'h0040_0000);
        check("ovf e_prev_1", e_prev_1, 32'h1FFC_0000);
        check("ovf w_1_new",  w_1_new,  exp_w1_ovf);
        check("ovf w_2_new",  w_2_new,  32'hFFC0_0000);
        check("ovf w_3_new",  w_3_new,  32'h0140_0000);
        check("ovf b_new",    b_new,    32'hFFC0_0000);
        finish_pass("ovf");

        // y = 1.0 gives a zero derivative: no change anywhere.
        apply(32'h0100_0000, 32'h0100_0000, 32'h0080_0000,
              32'h0100_0000, 32'h0200_0000, 32'hFF00_0000,
              32'h0080_0000, 32'h0040_0000, 32'h0100_0000, 32'h0010_0000);
        run_pass("zero", -1, -10, 9);
        check("zero delta",    delta,    32'h0);
        check("zero e_prev_1", e_prev_1, 32'h0);
        check("zero e_prev_2", e_prev_2, 32'h0);
        check("zero e_prev_3", e_prev_3, 32'h0);
        check("zero w_1_new",  w_1_new,  32'h0080_0000);
        check("zero w_2_new",  w_2_new,  32'h0040_0000);
        check("zero w_3_new",  w_3_new,  32'h0100_0000);
        check("zero b_new",    b_new,    32'h0010_0000);
        finish_pass("zero");

        // Reset in UPD aborts the pass immediately.
        apply_nominal();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst delta",    delta,    32'h0);
        check("rst e_prev_1", e_prev_1, 32'h0);
        check("rst w_1_new",  w_1_new,  32'h0);
        check("rst b_new",    b_new,    32'h0);
        check("rst busy",     32'(busy), 32'd0);
        check("rst done",     32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ndone_rst = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) ndone_rst++;
        end
        check("rst no done", 32'(ndone_rst), 32'd0);
        check("rst idle", 32'(busy), 32'd0);

        apply_nominal();
        run_pass("post", -1, -10, 9);
        check_nominal("post");
        finish_pass("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
